// File: rtl/prbs_lfsr.sv
// Fibonacci PRBS generator with a rejection-sampling front end that returns
// uniformly distributed values in [0, limit) drawn from the LFSR stream.
module prbs_lfsr #(
  parameter int unsigned            WIDTH   = 16,
  parameter logic [WIDTH-1:0]       SEED    = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned            RANGE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shiftEn,
  input  logic               seedLoad,
  input  logic [WIDTH-1:0]   seedIn,
  output logic [WIDTH-1:0]   outSeq,
  output logic               lockup,
  input  logic               reqValid,
  input  logic [RANGE_W-1:0] reqLimit,
  output logic               reqReady,
  output logic               rspValid,
  output logic [RANGE_W-1:0] rspValue,
  output logic               rspErr
);

  // Tap positions as a bit mask, selected by LFSR length.
  localparam logic [31:0] TAPS = (WIDTH == 8)  ? 32'h0000_00B8 :
                                 (WIDTH == 16) ? 32'h0000_B400 :
                                                 32'h8020_0003;

  typedef enum logic {IDLE, SAMPLE} state_e;

  state_e               fsm_q, fsm_d;
  logic [WIDTH-1:0]     lfsr_q, lfsr_d;
  logic [RANGE_W-1:0]   limit_q, limit_d;
  logic [RANGE_W-1:0]   mask_q, mask_d;
  logic [RANGE_W-1:0]   rsp_value_q, rsp_value_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 lockup_q, lockup_d;

  logic                 fb;
  logic                 sample_step;
  logic [RANGE_W-1:0]   req_mask;
  logic [RANGE_W-1:0]   cand;

  assign fb   = ^(lfsr_q & TAPS[WIDTH-1:0]);
  assign cand = lfsr_q[RANGE_W-1:0] & mask_q;

  // Smear the highest set bit of (limit-1) downward to get 2^k-1.
  always_comb begin
    req_mask = reqLimit - RANGE_W'(1);
    for (int unsigned i = 0; i < RANGE_W; i++) begin
      req_mask = req_mask | (req_mask >> 1);
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    limit_d     = limit_q;
    mask_d      = mask_q;
    rsp_value_d = rsp_value_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    sample_step = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (reqValid) begin
          if (reqLimit == '0) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_value_d = '0;
          end else begin
            fsm_d   = SAMPLE;
            limit_d = reqLimit;
            mask_d  = req_mask;
          end
        end
      end
      SAMPLE: begin
        sample_step = 1'b1;
        if (cand < limit_q) begin
          rsp_value_d = cand;
          rsp_valid_d = 1'b1;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // A zero seed would lock the LFSR at zero forever, so it is replaced by SEED.
  always_comb begin
    lockup_d = 1'b0;
    if (seedLoad) begin
      if (seedIn == '0) begin
        lfsr_d   = SEED;
        lockup_d = 1'b1;
      end else begin
        lfsr_d = seedIn;
      end
    end else if (sample_step || shiftEn) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], fb};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      lfsr_q      <= SEED;
      limit_q     <= '0;
      mask_q      <= '0;
      rsp_value_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      lfsr_q      <= lfsr_d;
      limit_q     <= limit_d;
      mask_q      <= mask_d;
      rsp_value_q <= rsp_value_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      lockup_q    <= lockup_d;
    end
  end

  assign outSeq   = lfsr_q;
  assign lockup   = lockup_q;
  assign reqReady = (fsm_q == IDLE);
  assign rspValid = rsp_valid_q;
  assign rspValue = rsp_value_q;
  assign rspErr   = rsp_err_q;

endmodule

// File: doc/prbs_lfsr.md
PRBS_LFSR -- requirements
Module: prbs_lfsr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the LFSR length; legal values 8, 16, 32.
REQ-002 The block SHALL have parameter SEED, default 1, the WIDTH-bit nonzero reset/recovery state.
REQ-003 The block SHALL have parameter RANGE_W, default 4, the bounded-value width; legal range 1..WIDTH.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port shiftEn  input  1  advances the LFSR one step per cycle while high.
REQ-007 The block SHALL have port seedLoad  input  1  loads seedIn into the LFSR.
REQ-008 The block SHALL have port seedIn  input  WIDTH  seed value.
REQ-009 The block SHALL have port outSeq  output  WIDTH  current LFSR state, registered.
REQ-010 The block SHALL have port lockup  output  1  one-cycle pulse: zero seed replaced by SEED.
REQ-011 The block SHALL have port reqValid  input  1  bounded-random request.
REQ-012 The block SHALL have port reqLimit  input  RANGE_W  exclusive upper bound of the requested value.
REQ-013 The block SHALL have port reqReady  output  1  high in IDLE; a request is accepted when reqValid and reqReady are both high.
REQ-014 The block SHALL have port rspValid  output  1  one-cycle pulse marking rspValue/rspErr valid.
REQ-015 The block SHALL have port rspValue  output  RANGE_W  result, 0 <= rspValue < limit.
REQ-016 The block SHALL have port rspErr  output  1  asserted with rspValid when limit was 0.

Function
REQ-017 The LFSR SHALL be Fibonacci, shifting left: next = {state[WIDTH-2:0], fb}.
REQ-018 The feedback fb SHALL be the XOR of these tap bits: WIDTH=8 uses 7,5,4,3; WIDTH=16 uses 15,13,12,10; WIDTH=32 uses 31,21,1,0.
REQ-019 The LFSR update priority each cycle SHALL be seedLoad, then FSM SAMPLE step, then shiftEn; otherwise the LFSR holds.
REQ-020 When seedLoad is high and seedIn is nonzero, the LFSR SHALL load seedIn on that edge.
REQ-021 When seedLoad is high and seedIn is zero, the LFSR SHALL load SEED and pulse lockup for one cycle in the next cycle.
REQ-022 The FSM SHALL have states IDLE and SAMPLE; reqReady SHALL be 1 only in IDLE.
REQ-023 In IDLE, on request acceptance the block SHALL capture reqLimit as limit.
REQ-024 On acceptance with limit=0, the block SHALL return rspValid=1, rspErr=1, rspValue=0 in the next cycle and stay in IDLE.
REQ-025 On acceptance with limit>0, the FSM SHALL move to SAMPLE and capture mask = smallest (2^k - 1) >= limit-1.
REQ-026 Each SAMPLE cycle SHALL compute cand = outSeq[RANGE_W-1:0] & mask.
REQ-027 In a SAMPLE cycle with cand < limit, rspValue SHALL be set to cand, rspValid SHALL pulse in the next cycle, and the FSM SHALL return to IDLE.
REQ-028 In a SAMPLE cycle with cand >= limit, the FSM SHALL stay in SAMPLE.
REQ-029 The LFSR SHALL advance one step on every SAMPLE cycle (accept or reject), regardless of shiftEn, unless seedLoad is high.
REQ-030 The minimum latency from acceptance edge to rspValid SHALL be 2 cycles; termination is guaranteed because the LFSR is maximal length.
REQ-031 seedLoad during SAMPLE SHALL take effect, and sampling SHALL continue on the new state.
REQ-032 rspValue SHALL hold its last value between pulses.
REQ-033 reqValid SHALL be ignored outside IDLE.

Reset
REQ-034 While rst=0, asynchronously: outSeq=SEED, FSM=IDLE, reqReady=1, rspValid=0, rspErr=0, rspValue=0, lockup=0.
REQ-035 A reset during SAMPLE SHALL abort the request with no rspValid.
REQ-036 Operation SHALL resume on the first rising edge after rst returns high.

Verification
REQ-037 WIDTH=16, SEED=1, shiftEn=1 for 11 cycles -> outSeq steps 0x0001, 0x0002, 0x0004 ... 0x0400, then 0x0801.
REQ-038 seedLoad=1 with seedIn=0 -> next cycle outSeq=SEED, lockup=1 for exactly one cycle; with seedIn=0xBEEF -> outSeq=0xBEEF.
REQ-039 reqLimit=1 accepted at edge N -> rspValid=1, rspValue=0, rspErr=0 at N+2; LFSR advanced exactly one step.
REQ-040 reqLimit=0 -> rspValid=1, rspErr=1, rspValue=0 one cycle after acceptance; reqReady stays 1.
REQ-041 500 back-to-back requests with reqLimit=5 -> every rspValue in 0..4, all five values occur, reqReady=0 only in SAMPLE.
REQ-042 rst=0 asserted mid-SAMPLE -> immediate outSeq=SEED, reqReady=1, no rspValid pulse afterward.
